// File: rtl/even_counter_pkg.sv
// Shared constants for the even-value up/down counter: default width and
// the encoding of the direction select.
package even_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : even_counter_pkg

// File: rtl/t_flip_flop.sv
// Single T flip-flop with synchronous active-high reset; toggles when t is high.
module t_flip_flop (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    logic q_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= 1'b0;
        end else begin
            q_reg <= q_reg ^ t;
        end
    end

    assign q = q_reg;

endmodule : t_flip_flop

// File: rtl/even_updown_counter.sv
// Even-only up/down counter (steps of 2) built from one T flip-flop per bit.
// Bit 0 never toggles; the upper bits are driven by ripple-free toggle gating.
module even_updown_counter
    import even_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             y,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] t_next;
    logic [WIDTH-1:0] q_state;

    // Counting by 2 is a plain binary counter on bits [WIDTH-1:1]: bit k
    // toggles when all bits between 1 and k-1 are 1 (up) or all 0 (down).
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign t_next[gi] = 1'b0;
            end else if (gi == 1) begin : g_step
                assign t_next[gi] = 1'b1;
            end else begin : g_upper
                logic up_term;
                logic down_term;
                assign up_term    = &q_state[gi-1:1];
                assign down_term  = ~(|q_state[gi-1:1]);
                assign t_next[gi] = (y == DIR_DOWN) ? down_term : up_term;
            end

            t_flip_flop u_tff (
                .clk   (clk),
                .reset (reset),
                .t     (t_next[gi]),
                .q     (q_state[gi])
            );
        end
    endgenerate

    assign q = q_state;

endmodule : even_updown_counter

// File: tb/tb_even_updown_counter.sv
// Self-checking bench: directed sequences plus random direction/reset cycles
// compared against an arithmetic modulo-2^WIDTH reference model.
module tb_even_updown_counter;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         reset;
    logic         y;
    logic [W-1:0] q;

    int checks  = 0;
    int errors  = 0;
    int model_q = 0;

    always #5 clk = ~clk;

    even_updown_counter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .y     (y),
        .q     (q)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Apply inputs, take one rising edge, advance the model, then check q.
    task automatic step(input logic r, input logic d, input string tag);
        reset = r;
        y     = d;
        @(posedge clk);
        if (r)
            model_q = 0;
        else if (d == 1'b0)
            model_q = (model_q + 2) % MOD;
        else
            model_q = (model_q - 2 + MOD) % MOD;
        #1;
        $display("%s: reset=%0b y=%0b q=%0d model=%0d", tag, r, d, q, model_q);
        check_val(tag, {{(32-W){1'b0}}, q}, model_q);
        check_val({tag, "_bit0"}, {31'b0, q[0]}, 32'd0);
    endtask

    int up_exp[8]   = '{2, 4, 6, 8, 10, 12, 14, 0};
    int down_exp[8] = '{14, 12, 10, 8, 6, 4, 2, 0};

    initial begin
        reset = 1'b1;
        y     = 1'b0;

        // Reset, then held reset with y=1 must keep q at zero.
        step(1'b1, 1'b0, "reset");
        check_val("reset_zero", {{(32-W){1'b0}}, q}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, "reset_hold");
            check_val("reset_hold_zero", {{(32-W){1'b0}}, q}, 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, "up");
            check_val("up_tbl", {{(32-W){1'b0}}, q}, up_exp[i]);
        end

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, "down");
            check_val("down_tbl", {{(32-W){1'b0}}, q}, down_exp[i]);
        end

        // Reversal at q=6.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "rev_up");
        check_val("rev_at6", {{(32-W){1'b0}}, q}, 32'd6);
        step(1'b0, 1'b1, "rev_down");
        check_val("rev_4", {{(32-W){1'b0}}, q}, 32'd4);
        step(1'b0, 1'b1, "rev_down");
        check_val("rev_2", {{(32-W){1'b0}}, q}, 32'd2);
        step(1'b0, 1'b0, "rev_up");
        check_val("rev_back4", {{(32-W){1'b0}}, q}, 32'd4);

        // Mid-count reset at q=10, then resume downward.
        step(1'b1, 1'b0, "mid_pre_reset");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "mid_up");
        check_val("mid_at10", {{(32-W){1'b0}}, q}, 32'd10);
        step(1'b1, 1'b0, "mid_reset");
        check_val("mid_zero", {{(32-W){1'b0}}, q}, 32'd0);
        step(1'b0, 1'b1, "mid_resume");
        check_val("mid_14", {{(32-W){1'b0}}, q}, 32'd14);

        // Random direction, with an occasional reset.
        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_even_updown_counter
